// File: rtl/data_bus_pkg.sv
// Shared types and constants for the data_m bus initiator.
package data_bus_pkg;

  localparam int ADDR_W = 20;

  localparam logic [1:0] BYTESEL_LO   = 2'b01;
  localparam logic [1:0] BYTESEL_HI   = 2'b10;
  localparam logic [1:0] BYTESEL_WORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    GAP,
    ACCESS2,
    FINISH
  } state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts stalled access cycles; expired is asserted in the last cycle allowed before abort.
module bus_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Fires on the LIMIT-th stalled cycle so access is low on the next one.
  assign expired = enable && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/data_bus_initiator.sv
// Initiator for the 16-bit data_m bus; splits unaligned word accesses into two byte accesses.
// Optional access timeout abort is compiled in with BUS_TIMEOUT_EN.
module data_bus_initiator
  import data_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_start,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wr,
  input  logic              req_word,
  input  logic [15:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       rdata,
  output logic              error,
  output logic [ADDR_W-2:0] data_m_addr,
  output logic [15:0]       data_m_data_out,
  input  logic [15:0]       data_m_data_in,
  output logic              data_m_access,
  input  logic              data_m_ack,
  output logic              data_m_wr_en,
  output logic [1:0]        data_m_bytesel,
  output state_t            dbg_state
);

  // Handshake: an access is a request held stable while data_m_access=1;
  // it completes on the first cycle data_m_ack is sampled 1 with access=1.
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q, word_q, split_q;
  logic [15:0]         wdata_q, rdata_q;
  logic                in_access, accept, ack_seen, expired;

  assign in_access = (state_q == ACCESS) || (state_q == ACCESS2);
  assign accept    = req_start && ((state_q == IDLE) || (state_q == FINISH));
  assign ack_seen  = in_access && data_m_ack;

`ifdef BUS_TIMEOUT_EN
  logic error_q;

  bus_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!in_access),
    .enable  (in_access && !data_m_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      error_q <= 1'b0;
    else if (accept)   error_q <= 1'b0;
    else if (expired)  error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign expired = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      word_q  <= 1'b0;
      split_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wr_q    <= req_wr;
        word_q  <= req_word;
        split_q <= req_word && req_addr[0];
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end else if (expired) begin
        rdata_q <= '0;
      end else if (ack_seen && !wr_q) begin
        if (state_q == ACCESS2)  rdata_q[15:8] <= data_m_data_in[7:0];
        else if (split_q)        rdata_q[7:0]  <= data_m_data_in[15:8];
        else if (word_q)         rdata_q       <= data_m_data_in;
        else if (addr_q[0])      rdata_q       <= {8'h00, data_m_data_in[15:8]};
        else                     rdata_q       <= {8'h00, data_m_data_in[7:0]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS: begin
        if (expired)       state_d = FINISH;
        else if (ack_seen) state_d = split_q ? GAP : FINISH;
      end
      GAP:     state_d = ACCESS2;
      ACCESS2: if (expired || ack_seen) state_d = FINISH;
      FINISH:  state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Second half of a split always targets the next word (address was odd).
  always_comb begin
    data_m_addr     = (state_q == ACCESS2) ? (addr_q[ADDR_W-1:1] + 1'b1) : addr_q[ADDR_W-1:1];
    data_m_access   = in_access;
    data_m_wr_en    = in_access && wr_q;
    data_m_bytesel  = 2'b00;
    data_m_data_out = {wdata_q[7:0], wdata_q[7:0]};
    if (word_q && !split_q) begin
      data_m_data_out = wdata_q;
    end else if (state_q == ACCESS2) begin
      data_m_data_out = {wdata_q[15:8], wdata_q[15:8]};
    end
    if (in_access) begin
      if (word_q && !split_q)     data_m_bytesel = BYTESEL_WORD;
      else if (state_q == ACCESS2) data_m_bytesel = BYTESEL_LO;
      else if (addr_q[0])          data_m_bytesel = BYTESEL_HI;
      else                         data_m_bytesel = BYTESEL_LO;
    end
  end

  assign busy      = (state_q == ACCESS) || (state_q == GAP) || (state_q == ACCESS2);
  assign done      = (state_q == FINISH);
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_bus_initiator.sv
// Directed bench for data_bus_initiator: inputs change and outputs are sampled on the falling edge.
module tb_data_bus_initiator;
  import data_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_start = 1'b0;
  logic [19:0] req_addr = '0;
  logic        req_wr = 1'b0;
  logic        req_word = 1'b0;
  logic [15:0] req_wdata = '0;
  logic        busy, done, error;
  logic [15:0] rdata;
  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_out;
  logic [15:0] data_m_data_in = '0;
  logic        data_m_access;
  logic        data_m_ack = 1'b0;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  state_t      dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  data_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .req_start(req_start), .req_addr(req_addr),
    .req_wr(req_wr), .req_word(req_word), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .error(error),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_data_in(data_m_data_in), .data_m_access(data_m_access),
    .data_m_ack(data_m_ack), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [19:0] a, input logic wr, input logic word, input logic [15:0] wd);
    req_start = 1'b1; req_addr = a; req_wr = wr; req_word = word; req_wdata = wd;
    @(negedge clk);
    req_start = 1'b0;
  endtask

  task automatic ack_once(input logic [15:0] d);
    data_m_ack = 1'b1; data_m_data_in = d;
    @(negedge clk);
    data_m_ack = 1'b0; data_m_data_in = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({busy, done, error, data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out, rdata} !== 59'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got b%b d%b e%b acc%b we%b bs%b a%h do%h rd%h required all zero",
               busy, done, error, data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out, rdata);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_aligned_write;
    issue(20'h00124, 1'b1, 1'b1, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({busy, data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out} !== {1'b1, 1'b1, 1'b1, 2'b11, 19'h00092, 16'hBEEF}) begin
        n_fail++;
        $display("FAIL aligned_write_bus cyc%0d: got acc%b we%b bs%b a%h do%h required acc1 we1 bs11 a00092 doBEEF",
                 i, data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out);
      end
      if (i < 2) @(negedge clk);
    end
    ack_once(16'h0000);
    n_checks++;
    if ({done, busy, data_m_access, error} !== 4'b1000) begin
      n_fail++; $display("FAIL aligned_write_done: got d%b b%b acc%b e%b required d1 b0 acc0 e0", done, busy, data_m_access, error);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL aligned_write_pulse: got d%b b%b required d0 b0", done, busy); end
  endtask

  task automatic test_odd_byte_read;
    issue(20'h00011, 1'b0, 1'b0, 16'h0000);
    n_checks++;
    if ({data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr} !== {1'b1, 1'b0, 2'b10, 19'h00008}) begin
      n_fail++; $display("FAIL odd_byte_bus: got acc%b we%b bs%b a%h required acc1 we0 bs10 a00008", data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr);
    end
    ack_once(16'h5A00);
    n_checks++;
    if ({done, rdata} !== {1'b1, 16'h005A}) begin n_fail++; $display("FAIL odd_byte_rdata: got d%b rd%h required d1 rd005A", done, rdata); end
    @(negedge clk);
  endtask

  task automatic test_split_read;
    issue(20'h00033, 1'b0, 1'b1, 16'h0000);
    n_checks++;
    if ({data_m_access, data_m_bytesel, data_m_addr} !== {1'b1, 2'b10, 19'h00019}) begin
      n_fail++; $display("FAIL split_read_acc1: got acc%b bs%b a%h required acc1 bs10 a00019", data_m_access, data_m_bytesel, data_m_addr);
    end
    ack_once(16'h1200);
    n_checks++;
    if ({data_m_access, busy, done} !== 3'b010) begin
      n_fail++; $display("FAIL split_read_gap: got acc%b b%b d%b required acc0 b1 d0", data_m_access, busy, done);
    end
    @(negedge clk);
    n_checks++;
    if ({data_m_access, data_m_bytesel, data_m_addr} !== {1'b1, 2'b01, 19'h0001A}) begin
      n_fail++; $display("FAIL split_read_acc2: got acc%b bs%b a%h required acc1 bs01 a0001A", data_m_access, data_m_bytesel, data_m_addr);
    end
    ack_once(16'h0034);
    n_checks++;
    if ({done, rdata} !== {1'b1, 16'h3412}) begin n_fail++; $display("FAIL split_read_rdata: got d%b rd%h required d1 rd3412", done, rdata); end
    @(negedge clk);
  endtask

  task automatic test_wrap_write;
    issue(20'hFFFFF, 1'b1, 1'b1, 16'hA55A);
    n_checks++;
    if ({data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out} !== {1'b1, 2'b10, 19'h7FFFF, 16'h5A5A}) begin
      n_fail++; $display("FAIL wrap_acc1: got we%b bs%b a%h do%h required we1 bs10 a7FFFF do5A5A", data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out);
    end
    ack_once(16'h0000);
    @(negedge clk);
    n_checks++;
    if ({data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out} !== {1'b1, 1'b1, 2'b01, 19'h00000, 16'hA5A5}) begin
      n_fail++; $display("FAIL wrap_acc2: got acc%b we%b bs%b a%h do%h required acc1 we1 bs01 a00000 doA5A5",
                         data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr, data_m_data_out);
    end
    ack_once(16'h0000);
    n_checks++;
    if ({done, error} !== 2'b10) begin n_fail++; $display("FAIL wrap_done: got d%b e%b required d1 e0", done, error); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    issue(20'h00040, 1'b1, 1'b0, 16'h12C3);
    n_checks++;
    if ({data_m_bytesel, data_m_addr, data_m_data_out} !== {2'b01, 19'h00020, 16'hC3C3}) begin
      n_fail++; $display("FAIL even_byte_write: got bs%b a%h do%h required bs01 a00020 doC3C3", data_m_bytesel, data_m_addr, data_m_data_out);
    end
    ack_once(16'h0000);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got d%b required d1", done); end
    issue(20'h00200, 1'b0, 1'b1, 16'h0000);
    n_checks++;
    if ({data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr} !== {1'b1, 1'b0, 2'b11, 19'h00100}) begin
      n_fail++; $display("FAIL b2b_second_acc: got acc%b we%b bs%b a%h required acc1 we0 bs11 a00100", data_m_access, data_m_wr_en, data_m_bytesel, data_m_addr);
    end
    ack_once(16'hCAFE);
    n_checks++;
    if ({done, rdata} !== {1'b1, 16'hCAFE}) begin n_fail++; $display("FAIL b2b_rdata: got d%b rd%h required d1 rdCAFE", done, rdata); end
    @(negedge clk);
  endtask

  task automatic test_stray_ack;
    data_m_ack = 1'b1; data_m_data_in = 16'hFFFF;
    @(negedge clk);
    data_m_ack = 1'b0; data_m_data_in = '0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, data_m_access, rdata} !== {3'b000, 16'hCAFE}) begin
      n_fail++; $display("FAIL stray_ack: got b%b d%b acc%b rd%h required b0 d0 acc0 rdCAFE", busy, done, data_m_access, rdata);
    end
  endtask

  task automatic test_reset_mid;
    issue(20'h00300, 1'b0, 1'b1, 16'h0000);
    n_checks++;
    if (data_m_access !== 1'b1) begin n_fail++; $display("FAIL reset_mid_start: got acc%b required acc1", data_m_access); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({data_m_access, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_abort: got acc%b b%b d%b required 000", data_m_access, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_mid_nodone cyc%0d: got d%b b%b required d0 b0", i, done, busy); end
    end
    issue(20'h00302, 1'b0, 1'b1, 16'h0000);
    n_checks++;
    if ({data_m_access, data_m_addr} !== {1'b1, 19'h00181}) begin
      n_fail++; $display("FAIL reset_mid_restart: got acc%b a%h required acc1 a00181", data_m_access, data_m_addr);
    end
    ack_once(16'h7777);
    n_checks++;
    if ({done, rdata} !== {1'b1, 16'h7777}) begin n_fail++; $display("FAIL reset_mid_rdata: got d%b rd%h required d1 rd7777", done, rdata); end
    @(negedge clk);
  endtask

  task automatic test_stall;
    int n_stall;
`ifdef BUS_TIMEOUT_EN
    n_stall = 4;
`else
    n_stall = 20;
`endif
    issue(20'h00400, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < n_stall; i++) begin
      n_checks++;
      if ({data_m_access, busy, error, data_m_addr} !== {3'b110, 19'h00200}) begin
        n_fail++; $display("FAIL stall_hold cyc%0d: got acc%b b%b e%b a%h required acc1 b1 e0 a00200", i, data_m_access, busy, error, data_m_addr);
      end
      if (i == 1) begin req_start = 1'b1; req_addr = 20'h00500; end
      @(negedge clk);
      req_start = 1'b0;
    end
`ifdef BUS_TIMEOUT_EN
    n_checks++;
    if ({data_m_access, done, error, rdata} !== {3'b011, 16'h0000}) begin
      n_fail++; $display("FAIL timeout_abort: got acc%b d%b e%b rd%h required acc0 d1 e1 rd0000", data_m_access, done, error, rdata);
    end
`else
    ack_once(16'h1357);
    n_checks++;
    if ({done, error, rdata} !== {2'b10, 16'h1357}) begin
      n_fail++; $display("FAIL stall_complete: got d%b e%b rd%h required d1 e0 rd1357", done, error, rdata);
    end
`endif
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL stall_idle: got d%b b%b required d0 b0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_aligned_write();
    test_odd_byte_read();
    test_split_read();
    test_wrap_write();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_initiator.md
Name: data_bus_initiator

Overview:
Initiator (master) side of the 16-bit data_m bus used by the memory-mapped peripheral registers. Accepts single byte/word read or write commands from an internal requester, e.g. a debug or DMA engine. Drives data_m_access/addr/wr_en/bytesel/data_out and waits for data_m_ack. Unaligned word accesses are split into two byte-lane accesses.

Parameters:
TIMEOUT_CYCLES, 255, cycles data_m_access may stay high without ack before abort (used only with BUS_TIMEOUT_EN)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_start  input  1  command strobe; accepted only when busy=0
req_addr  input  20  byte address
req_wr  input  1  1=write, 0=read
req_word  input  1  1=16-bit, 0=8-bit
req_wdata  input  16  write data; byte writes use [7:0]
busy  output  1  command in progress
done  output  1  one-cycle pulse at completion
rdata  output  16  read result, valid when done=1; held until next accept
error  output  1  valid with done; 1=timeout abort
data_m_addr  output  19  word address (byte address [19:1])
data_m_data_out  output  16  write data
data_m_data_in  input  16  read data from responder
data_m_access  output  1  access request
data_m_ack  input  1  responder acknowledge
data_m_wr_en  output  1  write enable
data_m_bytesel  output  2  [0]=low lane (even byte), [1]=high lane (odd byte)

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, error, data_m_access, data_m_wr_en = 0; data_m_bytesel=2'b00; data_m_addr, data_m_data_out, rdata = 0.
- Cycle N, IDLE, req_start=1: command and split flag registered; busy=1 from N+1; data_m_access=1 from N+1. req_start while busy ignored.
- Access phases:
  - Aligned word: one access, bytesel 11, data_out=req_wdata.
  - Byte at even addr: bytesel 01.
  - Byte at odd addr: bytesel 10.
  - Byte writes: data_out={wdata[7:0],wdata[7:0]} (replicated in both lanes).
  - Unaligned word (addr[0]=1, req_word=1): access 1 is addr[19:1], bytesel 10, lane data wdata[7:0]. Access 2 is (addr+1)[19:1], bytesel 01, lane data wdata[15:8]. addr+1 wraps 0xFFFFF->0x00000.
- States: IDLE -> ACCESS -> (ack, split pending) GAP -> ACCESS2 -> (ack) FINISH -> IDLE. Without a split, ACCESS -> (ack) FINISH.
- ACCESS and ACCESS2: access, addr, wr_en, bytesel and data_out held stable until data_m_ack is sampled 1.
- The cycle after an ack sampled 1, data_m_access=0. GAP gives at least one idle cycle between accesses, so registered-ack responders cannot double-ack.
- Read capture on ack:
  - Aligned word: rdata=data_in.
  - Even byte: rdata={8'h00,data_in[7:0]}.
  - Odd byte: rdata={8'h00,data_in[15:8]}.
  - Split read: access 1 gives rdata[7:0]=data_in[15:8]; access 2 gives rdata[15:8]=data_in[7:0].
- Latency: access begins 1 cycle after accept. FINISH is the cycle after the final ack: done=1, busy=0 in that same cycle, and a new req_start is accepted in FINISH.
- data_m_ack while data_m_access=0 is ignored.
- Reset mid-operation aborts immediately with no done pulse. Writes become unaffected at the next access.

Optional Feature:
BUS_TIMEOUT_EN
- Defined: a counter clears on every access start and increments each cycle with access=1 and ack=0. When it reaches TIMEOUT_CYCLES, the block drops access and goes to FINISH with done=1, error=1, rdata=0. Any remaining split access is skipped.
- Undefined: the block waits for ack indefinitely; error is tied 0; no counter logic.

Decomposition:
- Package data_bus_pkg holds:
  - state enum (IDLE, ACCESS, GAP, ACCESS2, FINISH)
  - bytesel constants BYTESEL_LO=2'b01, BYTESEL_HI=2'b10, BYTESEL_WORD=2'b11
  - address width constant 20
- One natural sub-module: bus_timeout_counter (clear/enable/expired), instantiated only under BUS_TIMEOUT_EN.

Test Plan:
- Aligned word write, addr 0x00124, wdata 0xBEEF, ack after 2 wait cycles -> one access: addr 0x00092, bytesel 11, data_out 0xBEEF, wr_en 1; done pulse 1 cycle after ack; error 0.
- Odd byte read, addr 0x00011, data_in 0x5A00 -> bytesel 10, addr 0x00008; rdata 0x005A.
- Unaligned word read, addr 0x00033, responder returns 0x1200 then 0x0034 -> accesses at 0x00019 (bytesel 10) and 0x0001A (bytesel 01), with data_m_access low for ≥1 cycle between them; rdata 0x3412.
- Wrap: unaligned word write addr 0xFFFFF, wdata 0xA55A -> accesses at word 0x7FFFF (bytesel 10, data 0x5A5A) then 0x00000 (bytesel 01, data 0xA5A5).
- Reset mid-access: drop reset_n during ACCESS with no ack -> access, busy, done all 0 immediately; no done pulse afterwards; req_start is accepted again after reset release.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, responder never acks -> access high for 4 cycles then low; done=1, error=1, rdata=0x0000. A req_start during busy is ignored.
